// File: rtl/sort_engine_param_if.sv
// Host-side bus of the selection sort engine: load/readback port, start
// request, sort mode and status.
//
// Handshake: i_start is a single-cycle request honoured only while o_busy is
// low; the engine answers with a single-cycle o_done pulse (o_err alongside
// when N was invalid). Host writes are honoured only while o_busy is low;
// o_rd_data is a combinational view of mem[i_addr] at all times.
interface sort_engine_param_if #(
  parameter int SIZE_ADDR = 4,
  parameter int SIZE_DATA = 8
);
  logic                   i_start;
  logic [SIZE_ADDR:0]     i_num_elems;
  logic                   i_descend;
  logic                   i_signed;
  logic                   i_wr_en;
  logic [SIZE_ADDR-1:0]   i_addr;
  logic [SIZE_DATA-1:0]   i_wr_data;
  logic [SIZE_DATA-1:0]   o_rd_data;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_err;
  logic [2*SIZE_ADDR-1:0] o_swap_cnt;

  // Host / testbench side
  modport master (
    output i_start, i_num_elems, i_descend, i_signed,
    output i_wr_en, i_addr, i_wr_data,
    input  o_rd_data, o_busy, o_done, o_err, o_swap_cnt
  );

  // Sort engine side
  modport slave (
    input  i_start, i_num_elems, i_descend, i_signed,
    input  i_wr_en, i_addr, i_wr_data,
    output o_rd_data, o_busy, o_done, o_err, o_swap_cnt
  );
endinterface

// File: rtl/sort_engine_param.sv
// In-place selection sort over an internal register-file RAM.
// One comparison per clock; ascending/descending and signed/unsigned modes
// are latched at start. The host loads and reads back the RAM through the
// same port; o_swap_cnt reports the swaps of the last sort.
// PATH_RAM names an optional preload image for flows that apply one to the
// RAM externally; the engine itself starts from whatever the host loads.
module sort_engine_param #(
  parameter int SIZE_ADDR = 4,
  parameter int SIZE_DATA = 8,
  parameter     PATH_RAM  = ""
) (
  input  logic                i_clk,
  input  logic                i_rst,
  sort_engine_param_if.slave  bus,
  output logic [2:0]          o_state
);

  localparam int DEPTH = 2 ** SIZE_ADDR;
  localparam logic [SIZE_ADDR:0]     DEPTH_N  = (SIZE_ADDR + 1)'(DEPTH);
  localparam logic [2*SIZE_ADDR-1:0] SWAP_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_INIT  = 3'd2,
    S_SCAN  = 3'd3,
    S_SWAP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                 state, state_nx;
  logic [SIZE_DATA-1:0]   mem [DEPTH];
  logic [SIZE_ADDR:0]     n_q;
  logic                   desc_q;
  logic                   sgn_q;
  logic [SIZE_ADDR-1:0]   i_q;
  logic [SIZE_ADDR-1:0]   j_q;
  logic [SIZE_ADDR-1:0]   min_idx;
  logic [SIZE_DATA-1:0]   min_val;
  logic [2*SIZE_ADDR-1:0] swap_cnt;
  logic                   last_j;
  logic                   last_i;
  logic                   n_bad;
  logic                   need_swap;

  // Strict comparison so that ties keep the earlier index.
  function automatic logic better(input logic [SIZE_DATA-1:0] a,
                                  input logic [SIZE_DATA-1:0] b,
                                  input logic desc,
                                  input logic sgn);
    logic lt;
    logic gt;
    if (sgn) begin
      lt = $signed(a) < $signed(b);
      gt = $signed(a) > $signed(b);
    end else begin
      lt = a < b;
      gt = a > b;
    end
    return desc ? gt : lt;
  endfunction

  assign last_j    = ({1'b0, j_q} == (n_q - 1'b1));
  assign last_i    = ({1'b0, i_q} == (n_q - 2'd2));
  assign n_bad     = (n_q > DEPTH_N);
  assign need_swap = (min_idx != i_q);

  assign bus.o_rd_data  = mem[bus.i_addr];
  assign bus.o_busy     = (state != S_IDLE);
  assign bus.o_done     = (state == S_DONE);
  assign bus.o_err      = (state == S_DONE) && n_bad;
  assign bus.o_swap_cnt = swap_cnt;
  assign o_state        = state;

  // State register; reset aborts any sort in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.i_start) state_nx = S_CHECK;
      S_CHECK: state_nx = (n_bad || (n_q < 2'd2)) ? S_DONE : S_INIT;
      S_INIT:  state_nx = S_SCAN;
      S_SCAN:  if (last_j) state_nx = S_SWAP;
      S_SWAP:  state_nx = last_i ? S_DONE : S_INIT;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Sort datapath: latched job parameters, loop indices, running minimum
  // and the swap counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      n_q      <= '0;
      desc_q   <= 1'b0;
      sgn_q    <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      min_idx  <= '0;
      min_val  <= '0;
      swap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            n_q      <= bus.i_num_elems;
            desc_q   <= bus.i_descend;
            sgn_q    <= bus.i_signed;
            swap_cnt <= '0;
          end
        end
        S_CHECK: i_q <= '0;
        S_INIT: begin
          min_idx <= i_q;
          min_val <= mem[i_q];
          j_q     <= i_q + 1'b1;
        end
        S_SCAN: begin
          if (better(mem[j_q], min_val, desc_q, sgn_q)) begin
            min_idx <= j_q;
            min_val <= mem[j_q];
          end
          if (!last_j) j_q <= j_q + 1'b1;
        end
        S_SWAP: begin
          if (need_swap && (swap_cnt != SWAP_MAX)) swap_cnt <= swap_cnt + 1'b1;
          if (!last_i) i_q <= i_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // RAM: host writes only while idle; the swap exchanges both entries on one
  // edge. Contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if ((state == S_IDLE) && bus.i_wr_en) begin
      mem[bus.i_addr] <= bus.i_wr_data;
    end else if ((state == S_SWAP) && need_swap) begin
      mem[i_q]     <= min_val;
      mem[min_idx] <= mem[i_q];
    end
  end

endmodule

// File: tb/tb_sort_engine_param.sv
// Directed bench for sort_engine_param: loads data, sorts in each mode,
// checks result RAM, swap count, latency, error pulse, busy-time
// lockout of host writes/starts, and reset mid-sort.
module tb_sort_engine_param;
  localparam int SA = 4;
  localparam int SD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state_dbg;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [SD-1:0] exp_q[$];

  int   done_cyc;
  int   busy_cyc;
  logic err_seen;

  sort_engine_param_if #(.SIZE_ADDR(SA), .SIZE_DATA(SD)) bus();

  sort_engine_param #(.SIZE_ADDR(SA), .SIZE_DATA(SD), .PATH_RAM("")) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus),
    .o_state(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_mem(input logic [SA-1:0] a, input logic [SD-1:0] d);
    @(negedge clk);
    bus.i_wr_en   = 1'b1;
    bus.i_addr    = a;
    bus.i_wr_data = d;
    @(posedge clk);
    #1 bus.i_wr_en = 1'b0;
  endtask

  task automatic load4(input logic [SD-1:0] d0, input logic [SD-1:0] d1,
                       input logic [SD-1:0] d2, input logic [SD-1:0] d3);
    write_mem(0, d0);
    write_mem(1, d1);
    write_mem(2, d2);
    write_mem(3, d3);
  endtask

  // Pops exp_q entries and compares against RAM addresses 0..n-1.
  task automatic check_ram(input int n, input string tag);
    logic [SD-1:0] e;
    for (int k = 0; k < n; k++) begin
      bus.i_addr = SA'(k);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", tag, k), bus.o_rd_data, e);
    end
  endtask

  // Issues a start and waits for o_done. done_c counts clock edges from the
  // start-sampling edge to the done cycle; busy_c counts busy cycles before it.
  // disturb injects a host write to address 2 and a second start mid-sort.
  task automatic run_sort(input int n, input bit desc, input bit sgn, input bit disturb,
                          output int done_c, output int busy_c, output logic err_s);
    int cyc;
    @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_num_elems = (SA + 1)'(n);
    bus.i_descend   = desc;
    bus.i_signed    = sgn;
    @(negedge clk);
    bus.i_start = 1'b0;
    cyc    = 1;
    done_c = 0;
    busy_c = 0;
    err_s  = 1'b0;
    while (cyc <= 500) begin
      if (disturb && cyc == 3) begin
        bus.i_wr_en     = 1'b1;
        bus.i_addr      = 2;
        bus.i_wr_data   = 8'hEE;
        bus.i_start     = 1'b1;
        bus.i_num_elems = 2;
        bus.i_descend   = 1'b1;
      end else if (disturb && cyc == 4) begin
        bus.i_wr_en     = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_descend   = desc;
        bus.i_num_elems = (SA + 1)'(n);
      end
      #1;
      if (bus.o_done) begin
        done_c = cyc;
        err_s  = bus.o_err;
        break;
      end
      if (bus.o_busy) busy_c++;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int   steps;
    logic found;

    bus.i_start     = 1'b0;
    bus.i_num_elems = '0;
    bus.i_descend   = 1'b0;
    bus.i_signed    = 1'b0;
    bus.i_wr_en     = 1'b0;
    bus.i_addr      = '0;
    bus.i_wr_data   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_err", bus.o_err, 0);
    check("rst_swap", bus.o_swap_cnt, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;

    // 1: ascending unsigned
    load4(8'h30, 8'h10, 8'h40, 8'h20);
    run_sort(4, 0, 0, 0, done_cyc, busy_cyc, err_seen);
    check("t1_done_cyc", done_cyc, 14);
    check("t1_busy_cyc", busy_cyc, 13);
    check("t1_err", err_seen, 0);
    check("t1_swap", bus.o_swap_cnt, 3);
    @(negedge clk);
    check("t1_idle_busy", bus.o_busy, 0);
    exp_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    check_ram(4, "t1_ram");

    // 2: descending signed, then ascending unsigned on the same data
    load4(8'hFF, 8'h7F, 8'h80, 8'h00);
    run_sort(4, 1, 1, 0, done_cyc, busy_cyc, err_seen);
    check("t2a_done_cyc", done_cyc, 14);
    check("t2a_swap", bus.o_swap_cnt, 3);
    @(negedge clk);
    exp_q = '{8'h7F, 8'h00, 8'hFF, 8'h80};
    check_ram(4, "t2a_ram");
    load4(8'hFF, 8'h7F, 8'h80, 8'h00);
    run_sort(4, 0, 0, 0, done_cyc, busy_cyc, err_seen);
    check("t2b_swap", bus.o_swap_cnt, 1);
    @(negedge clk);
    exp_q = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    check_ram(4, "t2b_ram");

    // 4: invalid N and trivial N
    run_sort(17, 0, 0, 0, done_cyc, busy_cyc, err_seen);
    check("t4_n17_done_cyc", done_cyc, 2);
    check("t4_n17_err", err_seen, 1);
    check("t4_n17_swap_clr", bus.o_swap_cnt, 0);
    @(negedge clk);
    check("t4_err_gone", bus.o_err, 0);
    exp_q = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    check_ram(4, "t4_ram");
    run_sort(0, 0, 0, 0, done_cyc, busy_cyc, err_seen);
    check("t4_n0_done_cyc", done_cyc, 2);
    check("t4_n0_err", err_seen, 0);
    run_sort(1, 1, 0, 0, done_cyc, busy_cyc, err_seen);
    check("t4_n1_done_cyc", done_cyc, 2);
    check("t4_n1_err", err_seen, 0);

    // 3: already sorted, and all-equal
    write_mem(0, 1); write_mem(1, 2); write_mem(2, 3); write_mem(3, 4); write_mem(4, 5);
    run_sort(5, 0, 0, 0, done_cyc, busy_cyc, err_seen);
    check("t3a_done_cyc", done_cyc, 20);
    check("t3a_swap", bus.o_swap_cnt, 0);
    @(negedge clk);
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    check_ram(5, "t3a_ram");
    write_mem(0, 5); write_mem(1, 5); write_mem(2, 5);
    run_sort(3, 0, 0, 0, done_cyc, busy_cyc, err_seen);
    check("t3b_done_cyc", done_cyc, 9);
    check("t3b_swap", bus.o_swap_cnt, 0);
    @(negedge clk);
    exp_q = '{8'd5, 8'd5, 8'd5};
    check_ram(3, "t3b_ram");

    // 5: write and restart while busy are ignored
    load4(8'h30, 8'h10, 8'h40, 8'h20);
    run_sort(4, 0, 0, 1, done_cyc, busy_cyc, err_seen);
    check("t5_done_cyc", done_cyc, 14);
    check("t5_swap", bus.o_swap_cnt, 3);
    @(negedge clk);
    check("t5_no_restart", bus.o_busy, 0);
    exp_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    check_ram(4, "t5_ram");

    // 6: reset mid-SCAN, then a fresh sort
    load4(8'h30, 8'h10, 8'h40, 8'h20);
    @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_num_elems = 4;
    bus.i_descend   = 1'b0;
    bus.i_signed    = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b0;
    found = 1'b0;
    steps = 0;
    while (steps < 100 && !found) begin
      #1;
      if (state_dbg == 3'd3 && bus.o_swap_cnt == 1) found = 1'b1;
      else begin
        @(negedge clk);
        steps++;
      end
    end
    check("t6_reach_scan", found, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", bus.o_busy, 0);
    check("t6_rst_done", bus.o_done, 0);
    check("t6_rst_swap", bus.o_swap_cnt, 0);
    check("t6_rst_state", state_dbg, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q = '{8'h10, 8'h30, 8'h40, 8'h20};
    check_ram(4, "t6_partial");
    run_sort(4, 0, 0, 0, done_cyc, busy_cyc, err_seen);
    check("t6_done_cyc", done_cyc, 14);
    check("t6_swap", bus.o_swap_cnt, 2);
    @(negedge clk);
    exp_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    check_ram(4, "t6_ram");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
